// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable timer controller that sequences one attached counter.
// The CPU programs CTRL/PRESCALE/LOAD over a 4-register bus. The FSM loads the
// counter, paces its increments through a prescaler and reloads or stops it on
// overflow, latching a maskable interrupt.
module timer_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       bus_addr,
  input  logic             bus_wr,
  input  logic             bus_rd,
  input  logic [WIDTH-1:0] bus_wdata,
  output logic [WIDTH-1:0] bus_rdata,
  output logic             cnt_en,
  output logic             cnt_we,
  output logic [WIDTH-1:0] cnt_data,
  input  logic [WIDTH-1:0] cnt_value,
  input  logic             cnt_overflow,
  output logic             irq,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [1:0] ADDR_LOAD     = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQ_EN  = 2;

  state_t           state_q,     state_d;
  logic [2:0]       ctrl_q,      ctrl_d;
  logic [WIDTH-1:0] prescale_q,  prescale_d;
  logic [WIDTH-1:0] load_q,      load_d;
  logic             irq_pend_q,  irq_pend_d;
  logic [WIDTH-1:0] presc_cnt_q, presc_cnt_d;
  logic [WIDTH-1:0] rdata_q,     rdata_d;
  logic             cnt_en_s;
  logic             cnt_we_s;

  logic wr_ctrl_s;
  logic wr_presc_s;
  logic wr_load_s;
  logic wr_status_s;
  logic stop_wr_s;

  assign wr_ctrl_s   = bus_wr && (bus_addr == ADDR_CTRL);
  assign wr_presc_s  = bus_wr && (bus_addr == ADDR_PRESCALE);
  assign wr_load_s   = bus_wr && (bus_addr == ADDR_LOAD);
  assign wr_status_s = bus_wr && (bus_addr == ADDR_STATUS);
  // A CTRL write clearing enable stops the timer and freezes the counter at once.
  assign stop_wr_s   = wr_ctrl_s && !bus_wdata[CTRL_ENABLE];

  // Register-file updates, FSM next state and counter strobes.
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    prescale_d  = prescale_q;
    load_d      = load_q;
    irq_pend_d  = irq_pend_q;
    presc_cnt_d = presc_cnt_q;
    cnt_en_s    = 1'b0;
    cnt_we_s    = 1'b0;

    if (wr_ctrl_s) begin
      ctrl_d = bus_wdata[2:0];
    end else begin
      ctrl_d = ctrl_q;
    end

    if (wr_presc_s) begin
      prescale_d = bus_wdata;
    end else begin
      prescale_d = prescale_q;
    end

    if (wr_load_s) begin
      load_d = bus_wdata;
    end else begin
      load_d = load_q;
    end

    // W1C first so a same-cycle overflow below wins.
    if (wr_status_s && bus_wdata[0]) begin
      irq_pend_d = 1'b0;
    end else begin
      irq_pend_d = irq_pend_q;
    end

    case (state_q)
      ST_IDLE: begin
        presc_cnt_d = '0;
        if (ctrl_q[CTRL_ENABLE] && !stop_wr_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        cnt_we_s    = 1'b1;
        presc_cnt_d = '0;
        if (stop_wr_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (cnt_overflow) begin
          irq_pend_d = 1'b1;
          if (ctrl_q[CTRL_ONESHOT]) begin
            ctrl_d[CTRL_ENABLE] = 1'b0;
            state_d             = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end else if (presc_cnt_q == prescale_q) begin
          cnt_en_s    = !stop_wr_s;
          presc_cnt_d = '0;
        end else begin
          presc_cnt_d = presc_cnt_q + WIDTH'(1);
        end

        // Stop request overrides any overflow-driven transition.
        if (stop_wr_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_d;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        presc_cnt_d = '0;
      end
    endcase
  end

  // Read-data mux; captures pre-write register values on the read edge.
  always_comb begin
    rdata_d = rdata_q;
    if (bus_rd) begin
      case (bus_addr)
        ADDR_CTRL:     rdata_d = {{(WIDTH-3){1'b0}}, ctrl_q};
        ADDR_PRESCALE: rdata_d = prescale_q;
        ADDR_LOAD:     rdata_d = cnt_value;
        ADDR_STATUS:   rdata_d = {{(WIDTH-3){1'b0}}, state_q, irq_pend_q};
        default:       rdata_d = '0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State and register file, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= 3'd0;
      prescale_q  <= '0;
      load_q      <= '0;
      irq_pend_q  <= 1'b0;
      presc_cnt_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      prescale_q  <= prescale_d;
      load_q      <= load_d;
      irq_pend_q  <= irq_pend_d;
      presc_cnt_q <= presc_cnt_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign cnt_en    = cnt_en_s;
  assign cnt_we    = cnt_we_s;
  assign cnt_data  = load_q;
  assign irq       = irq_pend_q & ctrl_q[CTRL_IRQ_EN];
  assign busy      = (state_q != ST_IDLE);

endmodule
